// File: rtl/lut_neuron_layer_pipe.sv
// Layer of NUM_NEURONS runtime-loadable LUT neurons evaluated in parallel on
// pre-gathered fan-in slices, with a one-deep registered output stage.
module lut_neuron_layer_pipe #(
  parameter  int IN_BITS     = 4,
  parameter  int OUT_BITS    = 2,
  parameter  int NUM_NEURONS = 4,
  localparam int NW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_we,
  input  logic [NW-1:0]                   cfg_neuron,
  input  logic [IN_BITS-1:0]              cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_wdata,
  input  logic                            cfg_commit,
  output logic                            armed
);

  localparam int DEPTH = 1 << IN_BITS;

  logic                            armed_q;
  logic                            out_valid_q;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data_q;
  logic [NUM_NEURONS*OUT_BITS-1:0] lookup;
  logic                            xfer;

  // The output register may be refilled in the same cycle it drains.
  assign in_ready  = armed_q && (!out_valid_q || out_ready);
  assign xfer      = in_valid && in_ready;
  assign armed     = armed_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // One table per neuron; out-of-range cfg_neuron values match no neuron.
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    logic [OUT_BITS-1:0] table_mem [DEPTH];
    logic                wr_en;

    assign wr_en = cfg_we && (cfg_neuron == NW'(n));

    // NOTE: table RAM deliberately has no reset so it maps onto distributed
    // RAM; contents survive rst_n and are undefined until written.
    always_ff @(posedge clk) begin
      if (wr_en) table_mem[cfg_addr] <= cfg_wdata;
    end

    // Asynchronous read: a same-cycle write is seen only from the next edge.
    assign lookup[n*OUT_BITS +: OUT_BITS] = table_mem[in_data[n*IN_BITS +: IN_BITS]];
  end

  // A write always disarms, and takes priority over a simultaneous commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else if (cfg_we) begin
      armed_q <= 1'b0;
    end else if (cfg_commit) begin
      armed_q <= 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= lookup;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_neuron_layer_pipe.sv
// Scoreboard bench for lut_neuron_layer_pipe: a default-sized layer plus a
// 5-neuron layer whose select field can encode out-of-range neuron indices.
module tb_lut_neuron_layer_pipe;

  localparam int IB = 4, OB = 2, NN = 4, NWM = 2;
  localparam int SIB = 2, SOB = 3, SNN = 5, SNW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default-sized layer
  logic              in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [NN*IB-1:0]  in_data = '0;
  logic [NN*OB-1:0]  out_data;
  logic              cfg_we = 1'b0, cfg_commit = 1'b0, armed;
  logic [NWM-1:0]    cfg_neuron = '0;
  logic [IB-1:0]     cfg_addr = '0;
  logic [OB-1:0]     cfg_wdata = '0;

  // small layer
  logic              s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
  logic [SNN*SIB-1:0] s_in_data = '0;
  logic [SNN*SOB-1:0] s_out_data;
  logic              s_cfg_we = 1'b0, s_cfg_commit = 1'b0, s_armed;
  logic [SNW-1:0]    s_cfg_neuron = '0;
  logic [SIB-1:0]    s_cfg_addr = '0;
  logic [SOB-1:0]    s_cfg_wdata = '0;

  lut_neuron_layer_pipe #(.IN_BITS(IB), .OUT_BITS(OB), .NUM_NEURONS(NN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .armed(armed));

  lut_neuron_layer_pipe #(.IN_BITS(SIB), .OUT_BITS(SOB), .NUM_NEURONS(SNN)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .cfg_we(s_cfg_we), .cfg_neuron(s_cfg_neuron),
    .cfg_addr(s_cfg_addr), .cfg_wdata(s_cfg_wdata), .cfg_commit(s_cfg_commit),
    .armed(s_armed));

  // reference model: plain truth tables and expected-output queues
  int tbl_m  [NN][1<<IB];
  int stbl_m [SNN][1<<SIB];
  logic [NN*OB-1:0]   exp_q[$];
  logic [SNN*SOB-1:0] s_exp_q[$];
  int errors = 0, checks = 0, pops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NN*OB-1:0] model_eval(input logic [NN*IB-1:0] w);
    logic [NN*OB-1:0] r;
    int a;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      a = int'(w >> (n*IB)) % (1 << IB);
      r[n*OB +: OB] = OB'(tbl_m[n][a]);
    end
    return r;
  endfunction

  function automatic logic [SNN*SOB-1:0] s_model_eval(input logic [SNN*SIB-1:0] w);
    logic [SNN*SOB-1:0] r;
    int a;
    r = '0;
    for (int n = 0; n < SNN; n++) begin
      a = int'(w >> (n*SIB)) % (1 << SIB);
      r[n*SOB +: SOB] = SOB'(stbl_m[n][a]);
    end
    return r;
  endfunction

  // monitors: compare whenever the DUT hands a word downstream
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got %0h with empty scoreboard at %0t", out_data, $time);
      end else begin
        check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_out_valid && s_out_ready) begin
      if (s_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL s_unexpected_out: got %0h with empty scoreboard at %0t", s_out_data, $time);
      end else begin
        check("s_out_data", 64'(s_out_data), 64'(s_exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int n, input int a, input int d);
    cfg_we = 1'b1; cfg_neuron = NWM'(n); cfg_addr = IB'(a); cfg_wdata = OB'(d);
    tick();
    cfg_we = 1'b0;
    if (n < NN) tbl_m[n][a] = d;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  // offer one word; expected value is taken from the model at the accepting edge
  task automatic send(input logic [NN*IB-1:0] w, input int budget);
    bit done = 0;
    in_valid = 1'b1; in_data = w;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model_eval(w));
        done = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %0h not accepted within %0d cycles", w, budget);
    end
  endtask

  task automatic s_cfg_write(input int n, input int a, input int d);
    s_cfg_we = 1'b1; s_cfg_neuron = SNW'(n); s_cfg_addr = SIB'(a); s_cfg_wdata = SOB'(d);
    tick();
    s_cfg_we = 1'b0;
    if (n < SNN) stbl_m[n][a] = d;
  endtask

  task automatic s_send(input logic [SNN*SIB-1:0] w);
    bit done = 0;
    s_in_valid = 1'b1; s_in_data = w;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (s_in_ready) begin
        s_exp_q.push_back(s_model_eval(w));
        done = 1;
      end
      tick();
    end
    s_in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL s_send_timeout: word %0h not accepted", w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    logic [NN*IB-1:0] w;

    // reset state
    #12;
    check("rst_armed", 64'(armed), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    #3 rst_n = 1'b1;
    tick();

    // no commit: input never accepted
    in_valid = 1'b1; in_data = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("unarmed_in_ready", 64'(in_ready), 64'(0));
      check("unarmed_out_valid", 64'(out_valid), 64'(0));
    end
    check("unarmed_armed", 64'(armed), 64'(0));
    in_valid = 1'b0;

    // neuron0 entry[a]=a[1:0], others entry[a]=~a[1:0]
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < (1 << IB); a++)
        cfg_write(n, a, (n == 0) ? (a % 4) : (3 - (a % 4)));
    check("preload_armed", 64'(armed), 64'(0));
    commit();
    check("commit_armed", 64'(armed), 64'(1));
    out_ready = 1'b1;
    send(16'h3A51, 5);
    check("latency_valid", 64'(out_valid), 64'(1));
    tick();
    check("drain_valid", 64'(out_valid), 64'(0));

    // random tables and traffic with random backpressure
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < (1 << IB); a++)
        cfg_write(n, a, int'($urandom_range(0, 3)));
    commit();
    fork
      for (int i = 0; i < 40; i++) send(NN*IB'($urandom), 60);
      begin
        for (int i = 0; i < 60; i++) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    tick(); tick();

    // backpressure: three words queued behind a stalled output
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 3; i++) send(NN*IB'($urandom), 30);
      begin
        tick();
        for (int i = 0; i < 4; i++) begin
          tick();
          check("hold_valid", 64'(out_valid), 64'(1));
          check("hold_in_ready", 64'(in_ready), 64'(0));
          if (exp_q.size() > 0) check("hold_data", 64'(out_data), 64'(exp_q[0]));
        end
        pops0 = pops;
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("bp_consecutive_pops", 64'(pops - pops0), 64'(3));
      end
    join
    tick();
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // write/read collision on neuron0 entry 5: lookup returns the old value
    cfg_write(0, 5, 1);
    commit();
    w = NN*IB'($urandom);
    w[IB-1:0] = 4'h5;
    in_valid = 1'b1; in_data = w;
    cfg_we = 1'b1; cfg_neuron = '0; cfg_addr = 4'h5; cfg_wdata = 2'b11;
    @(negedge clk);
    check("coll_in_ready", 64'(in_ready), 64'(1));
    exp_q.push_back(model_eval(w));
    check("coll_old_value", 64'(model_eval(w) & 2'b11), 64'(1));
    tick();
    tbl_m[0][5] = 3;
    cfg_we = 1'b0; in_valid = 1'b0;
    check("coll_armed", 64'(armed), 64'(0));
    check("coll_in_ready_after", 64'(in_ready), 64'(0));
    commit();
    send(w, 5);
    tick();

    // small layer: writes to indices 5..7 must not touch any table
    for (int n = 0; n < SNN; n++)
      for (int a = 0; a < (1 << SIB); a++)
        s_cfg_write(n, a, int'($urandom_range(0, 7)));
    s_cfg_commit = 1'b1; tick(); s_cfg_commit = 1'b0;
    check("s_armed", 64'(s_armed), 64'(1));
    for (int n = SNN; n < (1 << SNW); n++)
      for (int a = 0; a < (1 << SIB); a++)
        s_cfg_write(n, a, int'($urandom_range(0, 7)));
    check("s_oob_disarm", 64'(s_armed), 64'(0));
    s_cfg_commit = 1'b1; tick(); s_cfg_commit = 1'b0;
    for (int a = 0; a < (1 << SIB); a++)
      s_send({SNN{SIB'(a)}});
    for (int i = 0; i < 6; i++) s_send(SNN*SIB'($urandom));
    tick(); tick();
    check("s_drained", 64'(s_exp_q.size()), 64'(0));

    // reset with a word stalled in the output register
    out_ready = 1'b0;
    send(NN*IB'($urandom), 5);
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_armed", 64'(armed), 64'(0));
    check("async_rst_data", 64'(out_data), 64'(0));
    exp_q.delete();
    s_exp_q.delete();
    #13 rst_n = 1'b1;
    tick();
    commit();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(NN*IB'($urandom), 5);
    tick(); tick();
    check("final_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
